lcd_line_fetch: RTL and testbench

Pixel-data stage directly downstream of the LCD timing generator. It consumes that generator's DE/HSYNC/VSYNC/X/Y/AFTER_FRAME, prefetches each visible line from the framebuffer over a single-request burst read interface into a two-bank line buffer, and drives RGB pixel data to the panel pins. HSYNC/VSYNC/DE are re-aligned to the pixel data.

---
 rtl/lcd_line_fetch.sv | 190 +++++++++++++++++++
 tb/tb_lcd_line_fetch.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_line_fetch.sv
// Line prefetcher between the LCD timing generator and the panel pins.
// Bursts each visible line into a two-bank buffer and emits RGB with syncs realigned.
module lcd_line_fetch #(
    parameter int          HPIXELS        = 800,
    parameter int          VPIXELS        = 480,
    parameter int          X_BITS         = 10,
    parameter int          Y_BITS         = 9,
    parameter int          ADDR_BITS      = 32,
    parameter int unsigned STRIDE_BYTES   = 3200,
    parameter logic [23:0] UNDERRUN_COLOR = 24'hFF00FF,
    parameter bit          HSYNC_POLARITY = 1'b0,
    parameter bit          VSYNC_POLARITY = 1'b0
) (
    input  logic                 CLK_PXCLK,
    input  logic                 RESET,
    input  logic                 HSYNC_IN,
    input  logic                 VSYNC_IN,
    input  logic                 DE_IN,
    input  logic [X_BITS-1:0]    X_IN,
    input  logic [Y_BITS-1:0]    Y_IN,
    input  logic                 AFTER_FRAME,
    input  logic [ADDR_BITS-1:0] FB_BASE,
    output logic                 RD_REQ,
    output logic [ADDR_BITS-1:0] RD_ADDR,
    input  logic                 RD_ACK,
    input  logic                 RD_DVALID,
    input  logic [31:0]          RD_DATA,
    output logic [23:0]          PIXEL,
    output logic                 HSYNC_OUT,
    output logic                 VSYNC_OUT,
    output logic                 DE_OUT,
    output logic                 UNDERRUN,
    output logic                 FETCH_LATE
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    localparam int                   XI_BITS  = (HPIXELS > 1) ? $clog2(HPIXELS) : 1;
    localparam int                   CNT_BITS = $clog2(HPIXELS + 1);
    localparam logic [CNT_BITS-1:0]  CNT_LAST = CNT_BITS'(HPIXELS - 1);
    localparam logic [Y_BITS-1:0]    Y_LAST   = Y_BITS'(VPIXELS - 1);
    localparam logic [X_BITS:0]      X_LIMIT  = (X_BITS + 1)'(HPIXELS);
    localparam logic [ADDR_BITS-1:0] STRIDE   = ADDR_BITS'(STRIDE_BYTES);

    logic [1:0]           state_q, state_d;
    logic [CNT_BITS-1:0]  cnt_q, cnt_d;
    logic                 tgt_bank_q, tgt_bank_d;
    logic [1:0]           bank_valid_q, bank_valid_d;
    logic [ADDR_BITS-1:0] line_addr_q, line_addr_d;
    logic [ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
    logic                 fetch_late_q, fetch_late_d;
    logic                 de_in_d_q;

    logic trig_frame, trig_line, trigger, trig_bank, wr_en, complete;

    logic [23:0] mem [2][HPIXELS];
    logic [23:0] ram_rd_q;
    logic        sel_valid_q, de_s1_q, hs_s1_q, vs_s1_q;
    logic [23:0] pixel_q, pixel_d;
    logic        de_s2_q, hs_s2_q, vs_s2_q, underrun_q;

    logic unused_rd_data_hi;
    assign unused_rd_data_hi = ^RD_DATA[31:24];

    always_comb begin
        trig_frame = AFTER_FRAME;
        trig_line  = DE_IN & ~de_in_d_q & (Y_IN < Y_LAST);
        trigger    = trig_frame | trig_line;
        trig_bank  = trig_frame ? 1'b0 : ~Y_IN[0];
        wr_en      = RD_DVALID & ((state_q == ST_DATA) | ((state_q == ST_REQ) & RD_ACK));
        complete   = wr_en & (cnt_q == CNT_LAST);
    end

    // Completion is applied before the trigger so a same-cycle trigger both
    // starts the next fetch and wins the bank_valid clear when banks coincide.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tgt_bank_d   = tgt_bank_q;
        bank_valid_d = bank_valid_q;
        rd_addr_d    = rd_addr_q;
        fetch_late_d = fetch_late_q;
        line_addr_d  = line_addr_q;

        if (trig_frame) begin
            line_addr_d = FB_BASE;
        end else if (trig_line) begin
            line_addr_d = line_addr_q + STRIDE;
        end

        if ((state_q == ST_REQ) && RD_ACK) begin
            state_d = ST_DATA;
        end
        if (wr_en) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (complete) begin
            bank_valid_d[tgt_bank_q] = 1'b1;
            cnt_d                    = '0;
            state_d                  = ST_IDLE;
        end

        if (trigger) begin
            bank_valid_d[trig_bank] = 1'b0;
            if ((state_q == ST_IDLE) || complete) begin
                state_d    = ST_REQ;
                rd_addr_d  = line_addr_d;
                tgt_bank_d = trig_bank;
                cnt_d      = '0;
            end else begin
                fetch_late_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK_PXCLK) begin
        if (RESET) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            tgt_bank_q   <= 1'b0;
            bank_valid_q <= '0;
            line_addr_q  <= '0;
            rd_addr_q    <= '0;
            fetch_late_q <= 1'b0;
            de_in_d_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tgt_bank_q   <= tgt_bank_d;
            bank_valid_q <= bank_valid_d;
            line_addr_q  <= line_addr_d;
            rd_addr_q    <= rd_addr_d;
            fetch_late_q <= fetch_late_d;
            de_in_d_q    <= DE_IN;
        end
    end

    // Line buffer: write port from the burst, 1-cycle synchronous read for the panel.
    always_ff @(posedge CLK_PXCLK) begin
        if (wr_en && !RESET) begin
            mem[tgt_bank_q][XI_BITS'(cnt_q)] <= RD_DATA[23:0];
        end
        if ({1'b0, X_IN} < X_LIMIT) begin
            ram_rd_q <= mem[Y_IN[0]][XI_BITS'(X_IN)];
        end
    end

    always_comb begin
        pixel_d = '0;
        if (de_s1_q) begin
            pixel_d = sel_valid_q ? ram_rd_q : UNDERRUN_COLOR;
        end
    end

    always_ff @(posedge CLK_PXCLK) begin
        if (RESET) begin
            sel_valid_q <= 1'b0;
            de_s1_q     <= 1'b0;
            hs_s1_q     <= ~HSYNC_POLARITY;
            vs_s1_q     <= ~VSYNC_POLARITY;
            pixel_q     <= '0;
            de_s2_q     <= 1'b0;
            hs_s2_q     <= ~HSYNC_POLARITY;
            vs_s2_q     <= ~VSYNC_POLARITY;
            underrun_q  <= 1'b0;
        end else begin
            sel_valid_q <= bank_valid_q[Y_IN[0]];
            de_s1_q     <= DE_IN;
            hs_s1_q     <= HSYNC_IN;
            vs_s1_q     <= VSYNC_IN;
            pixel_q     <= pixel_d;
            de_s2_q     <= de_s1_q;
            hs_s2_q     <= hs_s1_q;
            vs_s2_q     <= vs_s1_q;
            underrun_q  <= underrun_q | (de_s1_q & ~sel_valid_q);
        end
    end

    assign RD_REQ     = (state_q == ST_REQ);
    assign RD_ADDR    = rd_addr_q;
    assign PIXEL      = pixel_q;
    assign HSYNC_OUT  = hs_s2_q;
    assign VSYNC_OUT  = vs_s2_q;
    assign DE_OUT     = de_s2_q;
    assign UNDERRUN   = underrun_q;
    assign FETCH_LATE = fetch_late_q;

endmodule

// File: tb/tb_lcd_line_fetch.sv
// Bench for lcd_line_fetch: drives frames, models the memory and the expected
// panel output at transaction level (per-bank line address, per-pixel framebuffer word).
module tb_lcd_line_fetch;

    localparam int          H   = 8;
    localparam int          V   = 4;
    localparam logic [31:0] S   = 32'h1000;
    localparam logic [23:0] MAG = 24'hFF00FF;

    logic        clk = 1'b0;
    logic        rst, hs_in, vs_in, de_in, af;
    logic [9:0]  x_in;
    logic [8:0]  y_in;
    logic [31:0] fb_base;
    logic        rd_req, rd_ack, rd_dv;
    logic [31:0] rd_addr, rd_data;
    logic [23:0] pixel;
    logic        hs_o, vs_o, de_o, und, late;

    lcd_line_fetch #(
        .HPIXELS(H), .VPIXELS(V), .X_BITS(10), .Y_BITS(9), .ADDR_BITS(32),
        .STRIDE_BYTES(S), .UNDERRUN_COLOR(MAG), .HSYNC_POLARITY(1'b0), .VSYNC_POLARITY(1'b0)
    ) dut (
        .CLK_PXCLK(clk), .RESET(rst), .HSYNC_IN(hs_in), .VSYNC_IN(vs_in), .DE_IN(de_in),
        .X_IN(x_in), .Y_IN(y_in), .AFTER_FRAME(af), .FB_BASE(fb_base),
        .RD_REQ(rd_req), .RD_ADDR(rd_addr), .RD_ACK(rd_ack), .RD_DVALID(rd_dv), .RD_DATA(rd_data),
        .PIXEL(pixel), .HSYNC_OUT(hs_o), .VSYNC_OUT(vs_o), .DE_OUT(de_o),
        .UNDERRUN(und), .FETCH_LATE(late)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0] px;
        logic        de, hs, vs, u;
    } out_t;

    localparam out_t RST_OUT = '{px: 24'h0, de: 1'b0, hs: 1'b1, vs: 1'b1, u: 1'b0};

    int checks = 0;
    int errors = 0;

    logic [31:0] seed;
    logic [31:0] m_line_addr, m_fetch_addr, m_addr;
    logic        m_busy, m_req, m_tgt, m_und, m_late, m_de_prev;
    logic        m_valid [2];
    logic [31:0] m_bank_addr [2];
    int          m_words, m_ackcnt, m_gapcnt, m_gap, m_tgt_line;
    out_t        e1, e2;
    int          ack_wait, gap_base, gap_big, gap_line, bubble_pct, stray_left;

    function automatic logic [31:0] fbword(input logic [31:0] a);
        return (a >> 2) ^ seed;
    endfunction

    task automatic check1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r);
        out_t        e;
        logic        ack, dv_cnt, dv_stray, trig, tbank;
        logic [31:0] taddr, w;
        logic        b;
        ack      = !r && m_req && (m_ackcnt >= ack_wait);
        dv_cnt   = 1'b0;
        dv_stray = 1'b0;
        if (!r && m_busy && m_words < H &&
            ((m_req && ack && m_gap == 0) || (!m_req && m_gapcnt >= m_gap)))
            dv_cnt = ($urandom_range(0, 99) >= bubble_pct);
        rd_data = $urandom;
        if (dv_cnt) rd_data = fbword(m_fetch_addr + 32'(4 * m_words));
        else if ((r && m_busy) || stray_left > 0) begin
            dv_stray = 1'b1;
            if (stray_left > 0) stray_left--;
        end
        rd_ack = ack;
        rd_dv  = dv_cnt | dv_stray;

        b    = y_in[0];
        w    = fbword(m_bank_addr[b] + 32'(4 * int'(x_in)));
        e.de = de_in;
        e.hs = hs_in;
        e.vs = vs_in;
        e.u  = de_in && !m_valid[b];
        e.px = !de_in ? 24'h0 : (m_valid[b] ? w[23:0] : MAG);
        rst  = r;
        @(posedge clk);

        if (r) begin
            stray_left = m_busy ? H - m_words - 1 : 0;
            m_busy = 0; m_req = 0; m_addr = '0; m_words = 0;
            m_valid[0] = 0; m_valid[1] = 0;
            m_und = 0; m_late = 0; m_de_prev = 0;
            e1 = RST_OUT; e2 = RST_OUT;
        end else begin
            m_und = m_und | e1.u;
            e2 = e1;
            e1 = e;
            trig  = 1'b0;
            tbank = 1'b0;
            taddr = m_line_addr;
            if (af) begin
                trig = 1'b1; tbank = 1'b0; taddr = fb_base;
            end else if (de_in && !m_de_prev && int'(y_in) < V - 1) begin
                trig = 1'b1; tbank = ~y_in[0]; taddr = m_line_addr + S;
            end
            if (dv_cnt) begin
                m_words++;
                if (m_words == H) begin
                    m_valid[m_tgt]     = 1'b1;
                    m_bank_addr[m_tgt] = m_fetch_addr;
                    m_busy             = 1'b0;
                end
            end
            if (m_req) begin
                if (ack) begin m_req = 1'b0; m_gapcnt = 0; end
                else m_ackcnt++;
            end else if (m_busy) m_gapcnt++;
            if (trig) begin
                m_line_addr    = taddr;
                m_valid[tbank] = 1'b0;
                if (!m_busy) begin
                    m_busy = 1'b1; m_req = 1'b1; m_addr = taddr; m_fetch_addr = taddr;
                    m_tgt = tbank; m_words = 0; m_ackcnt = 0; m_gapcnt = 0;
                    m_tgt_line = af ? 0 : int'(y_in) + 1;
                    m_gap = (m_tgt_line == gap_line) ? gap_big : gap_base;
                end else m_late = 1'b1;
            end
            m_de_prev = de_in;
        end
        #1;
        check1("pixel", 32'(pixel), 32'(e2.px));
        check1("de_out", 32'(de_o), 32'(e2.de));
        check1("hsync_out", 32'(hs_o), 32'(e2.hs));
        check1("vsync_out", 32'(vs_o), 32'(e2.vs));
        check1("underrun", 32'(und), 32'(m_und));
        check1("fetch_late", 32'(late), 32'(m_late));
        check1("rd_req", 32'(rd_req), 32'(m_req));
        if (m_req) check1("rd_addr", rd_addr, m_addr);
        if (r) check1("rd_addr_reset", rd_addr, 32'h0);
    endtask

    task automatic idle_inputs();
        de_in = 1'b0; hs_in = 1'b1; vs_in = 1'b1; af = 1'b0;
        x_in = 10'($urandom_range(0, 1023));
    endtask

    task automatic run_line(input int y, input int hb);
        y_in = 9'(y);
        for (int i = 0; i < hb; i++) begin
            idle_inputs();
            hs_in = !(i >= 1 && i < 3);
            step(1'b0);
        end
        for (int x = 0; x < H; x++) begin
            de_in = 1'b1; hs_in = 1'b1; x_in = 10'(x);
            step(1'b0);
        end
    endtask

    task automatic run_frame(input logic [31:0] base, input int vb);
        idle_inputs();
        af = 1'b1; fb_base = base; y_in = 9'(V - 1);
        step(1'b0);
        af = 1'b0; fb_base = $urandom;
        for (int i = 0; i < vb; i++) begin
            idle_inputs();
            vs_in = (i >= 2);
            step(1'b0);
        end
        for (int y = 0; y < V; y++) run_line(y, 6);
        for (int i = 0; i < 4; i++) begin
            idle_inputs();
            step(1'b0);
        end
    endtask

    initial begin
        seed = $urandom;
        ack_wait = 0; gap_base = 0; gap_big = 0; gap_line = -1; bubble_pct = 0; stray_left = 0;
        m_line_addr = '0; m_fetch_addr = '0; m_addr = '0; m_tgt = 1'b0; m_tgt_line = 0;
        m_busy = 0; m_req = 0; m_und = 0; m_late = 0; m_de_prev = 0;
        m_words = 0; m_ackcnt = 0; m_gapcnt = 0; m_gap = 0;
        m_valid[0] = 0; m_valid[1] = 0; m_bank_addr[0] = '0; m_bank_addr[1] = '0;
        e1 = RST_OUT; e2 = RST_OUT;
        idle_inputs(); y_in = '0; fb_base = '0; rd_ack = 0; rd_dv = 0; rd_data = '0; rst = 1'b1;

        step(1'b1);
        step(1'b1);

        // nominal frame, immediate ack, data from the acceptance cycle
        run_frame(32'h0000_1000, 14);

        // slow acknowledge: request and address must hold
        ack_wait = 3;
        run_frame(32'h0000_2000, 14);
        ack_wait = 0;

        // line 1 data arrives late: underrun on line 1, dropped trigger hits line 2
        gap_line = 1; gap_big = 16;
        run_frame(32'h0000_3000, 14);
        gap_line = -1;
        check1("underrun_sticky", 32'(und), 32'h1);
        check1("fetch_late_sticky", 32'(late), 32'h1);

        // reset in the middle of a burst while the memory keeps streaming
        idle_inputs();
        af = 1'b1; fb_base = 32'h0000_4000; y_in = 9'(V - 1);
        step(1'b0);
        idle_inputs();
        for (int i = 0; i < 3; i++) step(1'b0);
        step(1'b1);
        for (int i = 0; i < 6; i++) begin idle_inputs(); step(1'b0); end
        run_line(V - 1, 6);
        run_frame(32'h0000_5000, 14);

        // address wrap
        run_frame(32'hFFFF_F000, 14);

        for (int f = 0; f < 3; f++) begin
            ack_wait   = $urandom_range(0, 2);
            bubble_pct = $urandom_range(0, 30);
            run_frame($urandom & 32'hFFFF_FFFC, 14);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
